// File: rtl/if_pipe_stage.sv
// Instruction-fetch stage: drives a ready-handshaked instruction memory, and
// loads the IF/ID register while honouring stalls, flushes and PC redirects.
module if_pipe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Data_Hazard,
  input  logic        Control_Hazard,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [9:0]  jump_address,
  input  logic [9:0]  branch_address,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [9:0]  pc_plus4,
  output logic [31:0] instr,
  output logic        if_id_valid,
  output logic [1:0]  fsm_state
);

  // Memory handshake: a request is presented while imem_req=1 and completes in
  // the cycle imem_ready=1; address holds until then, reset may abandon it.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [9:0]  pc, pc_nxt, pc_inc;
  logic [9:0]  pend_addr, pend_addr_nxt;
  logic        pend_valid, pend_valid_nxt;
  logic [31:0] fetch_buf, fetch_buf_nxt;
  logic [31:0] deliver_word;
  logic [9:0]  target;
  logic        redirect, complete, advance, deliver;

  assign redirect  = Control_Hazard && (jump || branch_taken);
  assign target    = jump ? jump_address : branch_address;
  assign complete  = (state == BUSY) && imem_ready;
  // A word can only enter IF/ID when decode advances and no flush is active.
  assign advance   = Data_Hazard && !Control_Hazard;
  assign pc_inc    = pc + 10'd4;
  assign imem_addr = pc;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = BUSY;
      BUSY: if (complete && !redirect && !pend_valid && !advance) state_nxt = DONE;
      DONE: if (redirect || advance) state_nxt = BUSY;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req       = (state == BUSY);
    pc_nxt         = pc;
    pend_addr_nxt  = pend_addr;
    pend_valid_nxt = pend_valid;
    fetch_buf_nxt  = fetch_buf;
    deliver        = 1'b0;
    deliver_word   = fetch_buf;
    case (state)
      IDLE: if (redirect) pc_nxt = target;
      BUSY: begin
        if (redirect) begin
          if (complete) begin
            pc_nxt         = target;
            pend_valid_nxt = 1'b0;
          end else begin
            pend_valid_nxt = 1'b1;
            pend_addr_nxt  = target;
          end
        end else if (complete) begin
          if (pend_valid) begin
            // Word belongs to the abandoned path; drop it and take the target.
            pc_nxt         = pend_addr;
            pend_valid_nxt = 1'b0;
          end else if (advance) begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            pc_nxt       = pc_inc;
          end else begin
            fetch_buf_nxt = imem_rdata;
          end
        end
      end
      DONE: begin
        if (redirect) begin
          pc_nxt        = target;
          fetch_buf_nxt = '0;
        end else if (advance) begin
          deliver = 1'b1;
          pc_nxt  = pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
      fetch_buf  <= '0;
    end else begin
      pc         <= pc_nxt;
      pend_addr  <= pend_addr_nxt;
      pend_valid <= pend_valid_nxt;
      fetch_buf  <= fetch_buf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || Control_Hazard) begin
      pc_plus4    <= '0;
      instr       <= '0;
      if_id_valid <= 1'b0;
    end else if (deliver) begin
      pc_plus4    <= pc_inc;
      instr       <= deliver_word;
      if_id_valid <= 1'b1;
    end else if (Data_Hazard) begin
      pc_plus4    <= '0;
      instr       <= '0;
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: doc/if_pipe_stage.md
IF_PIPE_STAGE -- requirements
Module: if_pipe_stage

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit; reset is synchronous and active-high.
REQ-003 The block SHALL have the port Data_Hazard, input, 1 bit: 1 = pipeline may advance, 0 = stall.
REQ-004 The block SHALL have the port Control_Hazard, input, 1 bit: 1 = flush IF/ID this cycle.
REQ-005 The block SHALL have the ports jump and branch_taken, inputs, 1 bit each: redirect requests from the decode stage.
REQ-006 The block SHALL have the ports jump_address and branch_address, inputs, 10 bits each: redirect targets.
REQ-007 The block SHALL have the port imem_req, output, 1 bit: instruction memory request.
REQ-008 The block SHALL have the port imem_addr, output, 10 bits: byte address equal to the current PC.
REQ-009 The block SHALL have the port imem_ready, input, 1 bit: a request completes in a cycle where imem_req=1 and imem_ready=1.
REQ-010 The block SHALL have the port imem_rdata, input, 32 bits: word valid when imem_ready=1.
REQ-011 The block SHALL have the port pc_plus4, output, 10 bits: IF/ID register, fetched address + 4.
REQ-012 The block SHALL have the port instr, output, 32 bits: IF/ID register, fetched instruction.
REQ-013 The block SHALL have the port if_id_valid, output, 1 bit: 1 = instr is a real fetch, 0 = bubble.

Function
REQ-014 The PC SHALL be 10 bits; PC+4 SHALL wrap modulo 1024 (1020 -> 0).
REQ-015 The fetch FSM SHALL have the states IDLE, BUSY and DONE; imem_req=1 only in BUSY; imem_addr and PC SHALL hold stable while imem_req=1 and imem_ready=0.
REQ-016 IDLE SHALL go to BUSY unconditionally on the next cycle.
REQ-017 In BUSY with completion, Data_Hazard=1, no redirect and none pending: IF/ID <= {PC+4, imem_rdata, valid=1}; PC <= PC+4; stay in BUSY, giving one instruction per cycle.
REQ-018 In BUSY with completion and Data_Hazard=0, no redirect and none pending: imem_rdata SHALL be latched into a 32-bit fetch buffer; PC holds; go to DONE.
REQ-019 In DONE, imem_req SHALL be 0; on Data_Hazard=1: IF/ID <= {PC+4, buffer, valid=1}; PC <= PC+4; go to BUSY. On Data_Hazard=0, stay in DONE.
REQ-020 A redirect SHALL occur when Control_Hazard=1 and (jump or branch_taken); the target SHALL be jump_address if jump=1, else branch_address.
REQ-021 A redirect in IDLE or DONE, or in BUSY with completion in the same cycle: PC <= target; any buffered or returned word SHALL be discarded; go to BUSY.
REQ-022 A redirect in BUSY without completion: the target SHALL be stored as pending, and PC/imem_addr are unchanged. On the eventual completion the returned word SHALL be discarded, PC <= pending target, and the block stays in BUSY. A later redirect overwrites the pending target.
REQ-023 When Control_Hazard=1, IF/ID SHALL load {0, 0, valid=0} regardless of Data_Hazard; a buffered word SHALL be kept when no redirect occurs.
REQ-024 Otherwise, if Data_Hazard=0, IF/ID SHALL hold its value.
REQ-025 Otherwise, if Data_Hazard=1 and no word is delivered that cycle, IF/ID SHALL load the bubble {0, 0, valid=0}.
REQ-026 Priority SHALL be: reset > redirect/flush > stall > advance.

Reset
REQ-027 While reset=1 at a clock edge: state <= IDLE; PC, pc_plus4, instr <= 0; if_id_valid <= 0; pending redirect cleared; fetch buffer cleared; imem_req <= 0.
REQ-028 Reset SHALL take effect in any state, including BUSY with an outstanding request, which is abandoned; the memory SHALL tolerate imem_req dropping without imem_ready.

Verification
REQ-029 Reset released at edge 0, imem_ready=1, Data_Hazard=1, imem_rdata=addr-tagged -> imem_addr 0,4,8 on cycles 1,2,3; instr(0)/pc_plus4=4/valid=1 visible after edge 2.
REQ-030 imem_ready low for 3 cycles at addr 8, Data_Hazard=1 -> imem_addr held at 8; 3 bubbles (instr=0, valid=0); word@8 delivered with pc_plus4=12.
REQ-031 Completion at addr 12 with Data_Hazard=0 for 2 cycles -> DONE, imem_req=0, IF/ID held; Data_Hazard=1 -> word@12 in IF/ID, next imem_addr=16.
REQ-032 Control_Hazard=1, jump=1, branch_taken=1, jump_address=0x100, branch_address=0x040 -> IF/ID bubble; next imem_addr=0x100.
REQ-033 Redirect to 0x200 during a BUSY wait at 0x020, ready 2 cycles later -> word@0x020 never reaches IF/ID; next imem_addr=0x200.
REQ-034 PC=1020, ready=1 -> pc_plus4=0; next imem_addr=0. Reset=1 mid-BUSY -> next cycle imem_req=0, IF/ID=0, PC=0.
